// File: rtl/ma_stage.sv
// ma_stage: memory-access stage of the 32-bit in-order pipeline.
//
// Takes an Ex_Ma_t payload from EX over a valid/ready pipe. Non-memory
// instructions pass straight into the output register. Loads and stores
// are parked in a hold register while the data-memory request/grant/response
// handshake completes. The result then moves into the output register as an
// Ma_Rw_t payload for the writeback stage.
//
// Ports:
//   Clk, Rst            clock (rising edge), asynchronous active-low reset
//   Ex_Payld_i          EX payload (pc, aluresult, op2, instr, ctrl)
//   Ex_Valid_i/Ready_o  input handshake
//   Ma_Payld_o          writeback payload (pc, aluresult, ldresult, instr, ctrl)
//   Ma_Valid_o/Ready_i  output handshake
//   Dmem_Req_o/We_o     memory request, 1 = store
//   Dmem_Addr_o/Wdata_o byte address (aluresult) and store data (op2)
//   Dmem_Gnt_i          request accepted
//   Dmem_Rvalid_i/Rdata_i  load response
//   Misalign_o          misaligned-access flag, qualified by Ma_Valid_o
//
// Build option:
//   MA_ALIGN_CHECK_EN   when defined, loads/stores with aluresult[1:0] != 0
//                       skip the memory and complete with Misalign_o = 1.
//                       When undefined, Misalign_o is tied to 0.

package ma_pkg;

  typedef struct packed {
    logic isLd;
    logic isSt;
    logic regWe;
  } MaCtrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] op2;
    logic [31:0] instr;
    MaCtrl_t     ctrl;
  } Ex_Ma_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] ldresult;
    logic [31:0] instr;
    MaCtrl_t     ctrl;
  } Ma_Rw_t;

endpackage

module ma_stage
  import ma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  Ex_Ma_t            Ex_Payld_i,
  input  logic              Ex_Valid_i,
  output logic              Ex_Ready_o,
  output Ma_Rw_t            Ma_Payld_o,
  output logic              Ma_Valid_o,
  input  logic              Ma_Ready_i,
  output logic              Dmem_Req_o,
  output logic              Dmem_We_o,
  output logic [ADDR_W-1:0] Dmem_Addr_o,
  output logic [DATA_W-1:0] Dmem_Wdata_o,
  input  logic              Dmem_Gnt_i,
  input  logic              Dmem_Rvalid_i,
  input  logic [DATA_W-1:0] Dmem_Rdata_i,
  output logic              Misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    CMPL = 2'd3
  } State_t;

  State_t      r_state;
  State_t      w_nextState;
  Ex_Ma_t      r_hold;
  logic [31:0] r_ldData;
  Ma_Rw_t      r_out;
  logic        r_outValid;

  logic w_outFree;
  logic w_accept;
  logic w_isMem;
  logic w_misalign;
  logic w_loadNew;
  logic w_loadHold;

  // The output slot is free when empty or being drained this cycle.
  assign w_outFree  = !r_outValid || Ma_Ready_i;
  assign Ex_Ready_o = (r_state == IDLE) && w_outFree;
  assign w_accept   = Ex_Valid_i && Ex_Ready_o;
  assign w_isMem    = Ex_Payld_i.ctrl.isLd || Ex_Payld_i.ctrl.isSt;

  // Only one source can write the output register in a cycle: new
  // non-memory work is accepted only in IDLE, completions come from CMPL.
  assign w_loadNew  = w_accept && !w_isMem;
  assign w_loadHold = (r_state == CMPL) && w_outFree;

`ifdef MA_ALIGN_CHECK_EN
  logic r_holdMis;
  logic r_outMis;

  assign w_misalign = w_isMem && (Ex_Payld_i.aluresult[1:0] != 2'b00);

  // Misalign flag travels with the payload: hold register, then output.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_holdMis <= 1'b0;
      r_outMis  <= 1'b0;
    end else begin
      if (w_accept && w_isMem) begin
        r_holdMis <= w_misalign;
      end
      if (w_loadNew) begin
        r_outMis <= 1'b0;
      end else if (w_loadHold) begin
        r_outMis <= r_holdMis;
      end
    end
  end

  assign Misalign_o = r_outValid && r_outMis;
`else
  assign w_misalign = 1'b0;
  assign Misalign_o = 1'b0;
`endif

  // State register; async reset aborts any in-flight transaction.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A misaligned access skips the memory entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_isMem) begin
          w_nextState = w_misalign ? CMPL : REQ;
        end
      end
      REQ: begin
        if (Dmem_Gnt_i) begin
          w_nextState = r_hold.ctrl.isSt ? CMPL : RSP;
        end
      end
      RSP: begin
        if (Dmem_Rvalid_i) begin
          w_nextState = CMPL;
        end
      end
      CMPL: begin
        if (w_outFree) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Memory-side outputs are decoded from the state register so the
  // request drops as soon as reset asserts.
  assign Dmem_Req_o   = (r_state == REQ);
  assign Dmem_We_o    = (r_state == REQ) && r_hold.ctrl.isSt;
  assign Dmem_Addr_o  = (r_state == REQ) ? ADDR_W'(r_hold.aluresult) : '0;
  assign Dmem_Wdata_o = (r_state == REQ) ? DATA_W'(r_hold.op2) : '0;

  // Hold register and load data. Load data is cleared on accept so stores
  // and misaligned accesses report ldresult = 0; Rvalid only counts in RSP.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hold   <= '0;
      r_ldData <= '0;
    end else if (w_accept && w_isMem) begin
      r_hold   <= Ex_Payld_i;
      r_ldData <= '0;
    end else if ((r_state == RSP) && Dmem_Rvalid_i) begin
      r_ldData <= 32'(Dmem_Rdata_i);
    end
  end

  // Output register: filled from EX directly or from the hold register,
  // held while the writeback stage stalls, cleared when drained.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
    end else if (w_loadNew) begin
      r_out.pc        <= Ex_Payld_i.pc;
      r_out.aluresult <= Ex_Payld_i.aluresult;
      r_out.ldresult  <= '0;
      r_out.instr     <= Ex_Payld_i.instr;
      r_out.ctrl      <= Ex_Payld_i.ctrl;
      r_outValid      <= 1'b1;
    end else if (w_loadHold) begin
      r_out.pc        <= r_hold.pc;
      r_out.aluresult <= r_hold.aluresult;
      r_out.ldresult  <= r_ldData;
      r_out.instr     <= r_hold.instr;
      r_out.ctrl      <= r_hold.ctrl;
      r_outValid      <= 1'b1;
    end else if (Ma_Ready_i) begin
      r_outValid <= 1'b0;
    end
  end

  assign Ma_Payld_o = r_out;
  assign Ma_Valid_o = r_outValid;

endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: directed self-checking bench for ma_stage.
//
// Walks through reset, single and back-to-back ALU ops, a store with a
// delayed grant, a load with a delayed response, output back-pressure,
// misaligned access (either build), and reset during a transaction.
// Inputs change and outputs are checked 1 time unit after each rising edge.

module tb_ma_stage;
  import ma_pkg::*;

  logic        clock;
  logic        rst;
  Ex_Ma_t      exPayld;
  logic        exValid;
  logic        exReady;
  Ma_Rw_t      maPayld;
  logic        maValid;
  logic        maReady;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic        dmemGnt;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  ma_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk          (clock),
    .Rst          (rst),
    .Ex_Payld_i   (exPayld),
    .Ex_Valid_i   (exValid),
    .Ex_Ready_o   (exReady),
    .Ma_Payld_o   (maPayld),
    .Ma_Valid_o   (maValid),
    .Ma_Ready_i   (maReady),
    .Dmem_Req_o   (dmemReq),
    .Dmem_We_o    (dmemWe),
    .Dmem_Addr_o  (dmemAddr),
    .Dmem_Wdata_o (dmemWdata),
    .Dmem_Gnt_i   (dmemGnt),
    .Dmem_Rvalid_i(dmemRvalid),
    .Dmem_Rdata_i (dmemRdata),
    .Misalign_o   (misalign)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one EX-side payload; only the fields the checks look at vary.
  task automatic applyStimulus(input logic valid, input logic isLd,
                               input logic isSt, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] op2);
    exValid           = valid;
    exPayld.pc        = pc;
    exPayld.aluresult = alu;
    exPayld.op2       = op2;
    exPayld.instr     = 32'h0000_0033 ^ pc;
    exPayld.ctrl.isLd = isLd;
    exPayld.ctrl.isSt = isSt;
    exPayld.ctrl.regWe = !isSt;
  endtask

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    exPayld    = '0;
    exValid    = 1'b0;
    maReady    = 1'b1;
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b0;
    dmemRdata  = '0;

    // ---------------- reset state ----------------
    #1;
    checkOutput("rst_valid",    32'(maValid), 32'd0);
    checkOutput("rst_req",      32'(dmemReq), 32'd0);
    checkOutput("rst_we",       32'(dmemWe), 32'd0);
    checkOutput("rst_addr",     dmemAddr, 32'd0);
    checkOutput("rst_wdata",    dmemWdata, 32'd0);
    checkOutput("rst_alu",      maPayld.aluresult, 32'd0);
    checkOutput("rst_ld",       maPayld.ldresult, 32'd0);
    checkOutput("rst_misalign", 32'(misalign), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_exready", 32'(exReady), 32'd1);

    // ---------------- single ADD ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0010, 32'h5);
    tick();
    exValid = 1'b0;
    checkOutput("add_valid", 32'(maValid), 32'd1);
    checkOutput("add_alu",   maPayld.aluresult, 32'h0000_0010);
    checkOutput("add_ld",    maPayld.ldresult, 32'd0);
    checkOutput("add_pc",    maPayld.pc, 32'h0000_1000);
    checkOutput("add_req",   32'(dmemReq), 32'd0);
    tick();
    checkOutput("add_drain", 32'(maValid), 32'd0);

    // ---------------- back-to-back ADDs ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h1, 32'h0);
    tick();
    checkOutput("b2b1_valid", 32'(maValid), 32'd1);
    checkOutput("b2b1_alu",   maPayld.aluresult, 32'h1);
    checkOutput("b2b1_rdy",   32'(exReady), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1008, 32'h2, 32'h0);
    tick();
    checkOutput("b2b2_valid", 32'(maValid), 32'd1);
    checkOutput("b2b2_alu",   maPayld.aluresult, 32'h2);
    checkOutput("b2b2_rdy",   32'(exReady), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_100C, 32'h3, 32'h0);
    tick();
    exValid = 1'b0;
    checkOutput("b2b3_valid", 32'(maValid), 32'd1);
    checkOutput("b2b3_alu",   maPayld.aluresult, 32'h3);
    tick();
    checkOutput("b2b_drain", 32'(maValid), 32'd0);

    // ---------------- store, grant after 3 wait cycles ----------------
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    exValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("st_req",   32'(dmemReq), 32'd1);
      checkOutput("st_we",    32'(dmemWe), 32'd1);
      checkOutput("st_addr",  dmemAddr, 32'h0000_0100);
      checkOutput("st_wdata", dmemWdata, 32'hDEAD_BEEF);
      checkOutput("st_busy",  32'(exReady), 32'd0);
      dmemGnt = (i == 3);
      tick();
    end
    dmemGnt = 1'b0;
    checkOutput("st_cmpl_req",   32'(dmemReq), 32'd0);
    checkOutput("st_cmpl_busy",  32'(exReady), 32'd0);
    checkOutput("st_cmpl_valid", 32'(maValid), 32'd0);
    tick();
    checkOutput("st_valid", 32'(maValid), 32'd1);
    checkOutput("st_alu",   maPayld.aluresult, 32'h0000_0100);
    checkOutput("st_ld",    maPayld.ldresult, 32'd0);
    checkOutput("st_rdy",   32'(exReady), 32'd1);

    // ---------------- load, Rvalid 2 cycles after grant ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1014, 32'h0000_0200, 32'h0);
    tick();
    exValid = 1'b0;
    checkOutput("ld_req",  32'(dmemReq), 32'd1);
    checkOutput("ld_we",   32'(dmemWe), 32'd0);
    checkOutput("ld_addr", dmemAddr, 32'h0000_0200);
    dmemGnt    = 1'b1;
    dmemRvalid = 1'b1;
    dmemRdata  = 32'hBAD0_BAD0;
    tick();
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b0;
    checkOutput("ld_rsp_req",   32'(dmemReq), 32'd0);
    checkOutput("ld_rsp_valid", 32'(maValid), 32'd0);
    tick();
    checkOutput("ld_rsp2_valid", 32'(maValid), 32'd0);
    dmemRvalid = 1'b1;
    dmemRdata  = 32'h1234_5678;
    tick();
    dmemRvalid = 1'b0;
    dmemRdata  = '0;
    checkOutput("ld_cmpl_valid", 32'(maValid), 32'd0);
    tick();
    checkOutput("ld_valid", 32'(maValid), 32'd1);
    checkOutput("ld_data",  maPayld.ldresult, 32'h1234_5678);
    checkOutput("ld_alu",   maPayld.aluresult, 32'h0000_0200);
    tick();
    checkOutput("ld_drain", 32'(maValid), 32'd0);

    // ---------------- output back-pressure ----------------
    maReady = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1018, 32'h0000_0400, 32'h0);
    tick();
    exValid = 1'b0;
    dmemGnt = 1'b1;
    tick();
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b1;
    dmemRdata  = 32'hCAFE_F00D;
    tick();
    dmemRvalid = 1'b0;
    dmemRdata  = '0;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_101C, 32'h0000_0077, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(maValid), 32'd1);
      checkOutput("bp_ld",    maPayld.ldresult, 32'hCAFE_F00D);
      checkOutput("bp_alu",   maPayld.aluresult, 32'h0000_0400);
      checkOutput("bp_rdy",   32'(exReady), 32'd0);
      tick();
    end
    maReady = 1'b1;
    #1;
    checkOutput("bp_release_rdy", 32'(exReady), 32'd1);
    tick();
    exValid = 1'b0;
    checkOutput("bp_fill_valid", 32'(maValid), 32'd1);
    checkOutput("bp_fill_alu",   maPayld.aluresult, 32'h0000_0077);
    checkOutput("bp_fill_ld",    maPayld.ldresult, 32'd0);
    tick();
    checkOutput("bp_drain", 32'(maValid), 32'd0);

    // ---------------- stray Rvalid in IDLE ----------------
    dmemRvalid = 1'b1;
    dmemRdata  = 32'h5555_AAAA;
    tick();
    dmemRvalid = 1'b0;
    checkOutput("idle_rv_rdy",   32'(exReady), 32'd1);
    checkOutput("idle_rv_req",   32'(dmemReq), 32'd0);
    checkOutput("idle_rv_valid", 32'(maValid), 32'd0);

    // ---------------- misaligned load from 0x203 ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1020, 32'h0000_0203, 32'h0);
    tick();
    exValid = 1'b0;
`ifdef MA_ALIGN_CHECK_EN
    checkOutput("mis_req",  32'(dmemReq), 32'd0);
    checkOutput("mis_busy", 32'(exReady), 32'd0);
    tick();
    checkOutput("mis_valid", 32'(maValid), 32'd1);
    checkOutput("mis_flag",  32'(misalign), 32'd1);
    checkOutput("mis_ld",    maPayld.ldresult, 32'd0);
`else
    checkOutput("mis_req",  32'(dmemReq), 32'd1);
    checkOutput("mis_addr", dmemAddr, 32'h0000_0203);
    dmemGnt = 1'b1;
    tick();
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b1;
    dmemRdata  = 32'h0A0B_0C0D;
    tick();
    dmemRvalid = 1'b0;
    tick();
    checkOutput("mis_valid", 32'(maValid), 32'd1);
    checkOutput("mis_flag",  32'(misalign), 32'd0);
    checkOutput("mis_ld",    maPayld.ldresult, 32'h0A0B_0C0D);
`endif
    tick();
    checkOutput("mis_drain", 32'(maValid), 32'd0);

    // ---------------- reset pulsed while in RSP ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1024, 32'h0000_0500, 32'h0);
    tick();
    exValid = 1'b0;
    checkOutput("rsprst_req_before", 32'(dmemReq), 32'd1);
    dmemGnt = 1'b1;
    tick();
    dmemGnt = 1'b0;
    checkOutput("rsprst_in_rsp", 32'(exReady), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rsprst_req",   32'(dmemReq), 32'd0);
    checkOutput("rsprst_valid", 32'(maValid), 32'd0);
    #1;
    rst        = 1'b1;
    dmemRvalid = 1'b1;
    dmemRdata  = 32'hFFFF_0000;
    tick();
    dmemRvalid = 1'b0;
    dmemRdata  = '0;
    checkOutput("rsprst_idle",       32'(exReady), 32'd1);
    checkOutput("rsprst_late_valid", 32'(maValid), 32'd0);
    tick();
    checkOutput("rsprst_late_valid2", 32'(maValid), 32'd0);

    // ---------------- reset in REQ drops the request at once ----------------
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1028, 32'h0000_0600, 32'h1111_2222);
    tick();
    exValid = 1'b0;
    checkOutput("reqrst_req_before", 32'(dmemReq), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("reqrst_req",  32'(dmemReq), 32'd0);
    checkOutput("reqrst_addr", dmemAddr, 32'd0);
    #1;
    rst = 1'b1;
    tick();
    checkOutput("reqrst_idle", 32'(exReady), 32'd1);
    checkOutput("reqrst_req2", 32'(dmemReq), 32'd0);

    // ---------------- normal operation after reset ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0ABC, 32'h0);
    tick();
    exValid = 1'b0;
    checkOutput("post_valid", 32'(maValid), 32'd1);
    checkOutput("post_alu",   maPayld.aluresult, 32'h0000_0ABC);
    checkOutput("post_pc",    maPayld.pc, 32'h0000_2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
